// File: rtl/alu_decode_stage_pkg.sv
// Shared opcode, funct3 and ALU-select encodings for the decode stage,
// plus the funct3-to-ALU mapping common to OP and OP_IMM.
package alu_decode_stage_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_e;

   // alt is inst[30]; sub_ok is low for OP_IMM, where bit 30 is immediate data for ADDI
   function automatic alu_op_e f3_sel(input logic [2:0] f3, input logic alt, input logic sub_ok);
      alu_op_e r;
      case (f3)
         F3_ADD:  r = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
         F3_SLL:  r = ALU_SLL;
         F3_SLT:  r = ALU_SLT;
         F3_SLTU: r = ALU_SLTU;
         F3_XOR:  r = ALU_XOR;
         F3_SR:   r = alt ? ALU_SRA : ALU_SRL;
         F3_OR:   r = ALU_OR;
         default: r = ALU_AND;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/alu_decode_stage_imm_gen.sv
// Immediate generator: I/S/U immediates sign-extended to XLEN and the
// zero-extended shift amount. Opcode bits are not needed, so only inst[31:7] enters.
module imm_gen #(
   parameter int XLEN = 32
) (
   input  logic [31:7]     inst,
   output logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] imm_s,
   output logic [XLEN-1:0] imm_u,
   output logic [XLEN-1:0] shamt
);

   logic signed [11:0] raw_i;
   logic signed [11:0] raw_s;
   logic signed [31:0] raw_u;

   assign raw_i = inst[31:20];
   assign raw_s = {inst[31:25], inst[11:7]};
   assign raw_u = {inst[31:12], 12'b0};

   assign imm_i = XLEN'(raw_i);
   assign imm_s = XLEN'(raw_s);
   assign imm_u = XLEN'(raw_u);

   // RV64 shifts use a 6-bit shamt; bit 25 belongs to funct7 on RV32
   assign shamt = (XLEN == 64) ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);

endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: combinational decode captured into a
// 2-entry skid buffer (output reg O, skid reg S) so in_ready is a pure register.
module alu_decode_stage
   import alu_decode_stage_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int SEL_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      inst,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  op1,
   output logic [XLEN-1:0]  op2,
   output logic [SEL_W-1:0] alu_sel,
   output logic             illegal
);

   typedef struct packed {
      logic [XLEN-1:0]  op1;
      logic [XLEN-1:0]  op2;
      logic [SEL_W-1:0] sel;
      logic             illegal;
   } entry_t;

   logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt;
   logic [2:0]      funct3;
   alu_op_e         alu_op;
   entry_t          dec, o_q, s_q;
   logic            o_vld, s_vld;
   logic            accept, fire, o_free;

   assign funct3 = inst[14:12];

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .inst  (inst[31:7]),
      .imm_i (imm_i),
      .imm_s (imm_s),
      .imm_u (imm_u),
      .shamt (shamt)
   );

   always_comb begin
      dec    = '0;
      alu_op = ALU_ADD;
      case (inst[6:0])
         OPC_OP: begin
            dec.op1 = rs1;
            dec.op2 = rs2;
            alu_op  = f3_sel(funct3, inst[30], 1'b1);
         end
         OPC_OP_IMM: begin
            dec.op1 = rs1;
            dec.op2 = (funct3 == F3_SLL || funct3 == F3_SR) ? shamt : imm_i;
            alu_op  = f3_sel(funct3, inst[30], 1'b0);
         end
         OPC_LUI: dec.op2 = imm_u;
         OPC_AUIPC: begin
            dec.op1 = pc;
            dec.op2 = imm_u;
         end
         OPC_LOAD: begin
            dec.op1 = rs1;
            dec.op2 = imm_i;
         end
         OPC_STORE: begin
            dec.op1 = rs1;
            dec.op2 = imm_s;
         end
         OPC_BRANCH: begin
            dec.op1 = rs1;
            dec.op2 = rs2;
            case (funct3)
               F3_BLT, F3_BGE:   alu_op = ALU_SLT;
               F3_BLTU, F3_BGEU: alu_op = ALU_SLTU;
               default:          alu_op = ALU_SUB;
            endcase
         end
         OPC_JAL, OPC_JALR: begin
            dec.op1 = pc;
            dec.op2 = XLEN'(4);
         end
         default: dec.illegal = 1'b1;
      endcase
      dec.sel = SEL_W'(alu_op);
   end

   assign accept = in_valid && !s_vld;
   assign fire   = o_vld && out_ready;
   // O can take new data this edge: empty now, or its current entry leaves
   assign o_free = fire || !o_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_vld <= 1'b0;
         s_vld <= 1'b0;
      end else if (flush) begin
         o_vld <= 1'b0;
         s_vld <= 1'b0;
      end else if (o_free) begin
         o_vld <= s_vld || accept;
         s_vld <= 1'b0;
      end else if (accept) begin
         s_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_q <= '0;
         s_q <= '0;
      end else if (o_free) begin
         if (s_vld)       o_q <= s_q;
         else if (accept) o_q <= dec;
      end else if (accept) begin
         s_q <= dec;
      end
   end

   assign in_ready  = !s_vld;
   assign out_valid = o_vld;
   assign op1       = o_q.op1;
   assign op2       = o_q.op2;
   assign alu_sel   = o_q.sel;
   assign illegal   = o_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed cases plus randomized traffic on an
// XLEN=32 instance checked each cycle against a queue model; directed XLEN=64 cases.
module tb_alu_decode_stage;

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [4:0]  sel;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] inst = '0, pc = '0, rs1 = '0, rs2 = '0;
   logic        in_ready, out_valid, illegal;
   logic [31:0] op1, op2;
   logic [4:0]  alu_sel;

   logic        v_in_valid = 1'b0;
   logic [31:0] v_inst = '0;
   logic [63:0] v_pc = '0, v_rs1 = '0, v_rs2 = '0;
   logic        v_in_ready, v_out_valid, v_illegal;
   logic [63:0] v_op1, v_op2;
   logic [4:0]  v_sel;

   int   vectors = 0;
   int   miscompares = 0;
   exp_t q[$];
   exp_t e;
   bit   m_fire, m_acc;

   always #5 clk = ~clk;

   alu_decode_stage #(.XLEN(32), .SEL_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .inst(inst), .pc(pc), .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
      .op1(op1), .op2(op2), .alu_sel(alu_sel), .illegal(illegal)
   );

   alu_decode_stage #(.XLEN(64), .SEL_W(5)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(1'b0), .in_valid(v_in_valid), .in_ready(v_in_ready),
      .inst(v_inst), .pc(v_pc), .rs1(v_rs1), .rs2(v_rs2), .out_valid(v_out_valid), .out_ready(1'b1),
      .op1(v_op1), .op2(v_op2), .alu_sel(v_sel), .illegal(v_illegal)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode written straight from the operand/select table (RV32)
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r1,
                                  input logic [31:0] r2);
      exp_t m;
      int   tab[8];
      int   f3;
      logic [31:0] ii, si, ui;
      tab = '{0, 2, 3, 4, 5, 6, 8, 9};
      f3  = int'(i[14:12]);
      ii  = 32'($signed(i[31:20]));
      si  = 32'($signed({i[31:25], i[11:7]}));
      ui  = {i[31:12], 12'h000};
      m.op1 = 0; m.op2 = 0; m.sel = 0; m.ill = 0;
      case (i[6:0])
         7'h33: begin
            m.op1 = r1; m.op2 = r2; m.sel = 5'(tab[f3]);
            if (f3 == 0 && i[30]) m.sel = 1;
            if (f3 == 5 && i[30]) m.sel = 7;
         end
         7'h13: begin
            m.op1 = r1;
            m.op2 = (f3 == 1 || f3 == 5) ? 32'(i[24:20]) : ii;
            m.sel = 5'(tab[f3]);
            if (f3 == 5 && i[30]) m.sel = 7;
         end
         7'h37: m.op2 = ui;
         7'h17: begin m.op1 = p; m.op2 = ui; end
         7'h03: begin m.op1 = r1; m.op2 = ii; end
         7'h23: begin m.op1 = r1; m.op2 = si; end
         7'h63: begin
            m.op1 = r1; m.op2 = r2;
            m.sel = (f3 < 2) ? 5'd1 : (f3 < 6) ? 5'd3 : 5'd4;
         end
         7'h6F, 7'h67: begin m.op1 = p; m.op2 = 4; end
         default: m.ill = 1;
      endcase
      return m;
   endfunction

   // Occupancy model: up to two entries in order; flush and reset empty it
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) q.delete();
      else if (flush) q.delete();
      else begin
         m_fire = (q.size() > 0) && out_ready;
         m_acc  = in_valid && (q.size() < 2);
         if (m_fire) void'(q.pop_front());
         if (m_acc) q.push_back(model(inst, pc, rs1, rs2));
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("out_valid", out_valid, q.size() > 0);
         chk("in_ready", in_ready, q.size() < 2);
         if (q.size() > 0) begin
            chk("op1", op1, q[0].op1);
            chk("op2", op2, q[0].op2);
            chk("alu_sel", alu_sel, q[0].sel);
            chk("illegal", illegal, q[0].ill);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                        input logic [31:0] b);
      in_valid = v; inst = i; pc = p; rs1 = a; rs2 = b;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_op1"}, op1, 0);
      chk({tag, "_op2"}, op2, 0);
      chk({tag, "_sel"}, alu_sel, 0);
      chk({tag, "_illegal"}, illegal, 0);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] r;
      logic [6:0]  opc[13];
      opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67,
              7'h7F, 7'h0F, 7'h73, 7'h2B};
      r = $urandom;
      r[6:0] = opc[$urandom_range(0, 12)];
      if (r[6:0] == 7'h63 && !r[14]) r[13] = 1'b0;
      return r;
   endfunction

   initial begin
      // Model pinned to hand-computed values
      e = model(32'hFFF10093, 0, 5, 0);
      chk("pin_addi_op2", e.op2, 32'hFFFFFFFF);
      e = model(32'h4030D093, 0, 9, 0);
      chk("pin_srai_op2", e.op2, 3);
      chk("pin_srai_sel", e.sel, 7);
      e = model(32'hFE112E23, 0, 0, 0);
      chk("pin_sw_op2", e.op2, 32'hFFFFFFFC);

      #2;
      chk_reset("rst");
      chk("rst64_op2", v_op2, 0);
      chk("rst64_in_ready", v_in_ready, 1);
      #21 rst_n = 1'b1;

      out_ready = 1'b1;
      offer(1, 32'hFFF10093, 0, 5, 7);
      step();
      chk("addi_op1", op1, 5);
      chk("addi_op2", op2, 32'hFFFFFFFF);
      chk("addi_sel", alu_sel, 0);
      chk("addi_valid", out_valid, 1);
      offer(1, 32'h40208033, 0, 10, 3);
      step();
      chk("sub_sel", alu_sel, 1);
      chk("sub_op2", op2, 3);
      offer(1, 32'h4030D093, 0, 32'h80000000, 0);
      step();
      chk("srai_sel", alu_sel, 7);
      chk("srai_op2", op2, 3);
      offer(1, 32'h12345097, 32'h100, 1, 2);
      step();
      chk("auipc_op1", op1, 32'h100);
      chk("auipc_op2", op2, 32'h12345000);
      chk("auipc_sel", alu_sel, 0);
      offer(1, 32'hFE112E23, 0, 32'h2000, 0);
      step();
      chk("sw_op2", op2, 32'hFFFFFFFC);
      offer(1, 32'h0000007F, 4, 5, 6);
      step();
      chk("ill_flag", illegal, 1);
      chk("ill_op1", op1, 0);
      chk("ill_op2", op2, 0);
      offer(0, 0, 0, 0, 0);
      step();

      // Backpressure: third offer must stall until the first fire
      out_ready = 1'b0;
      offer(1, 32'h00100093, 0, 1, 0);
      step();
      chk("bp_ready1", in_ready, 1);
      offer(1, 32'h00100093, 0, 2, 0);
      step();
      chk("bp_ready2", in_ready, 0);
      offer(1, 32'h00100093, 0, 3, 0);
      step();
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_op1", op1, 1);
      out_ready = 1'b1;
      step();
      chk("bp_drain1_op1", op1, 2);
      chk("bp_drain1_ready", in_ready, 1);
      step();
      chk("bp_drain2_op1", op1, 3);
      offer(0, 0, 0, 0, 0);
      step();
      chk("bp_empty", out_valid, 0);

      // Flush with both entries held and a new offer pending
      out_ready = 1'b0;
      offer(1, 32'h00000033, 0, 8, 9);
      step();
      step();
      flush = 1'b1;
      step();
      chk("flush_valid", out_valid, 0);
      chk("flush_ready", in_ready, 1);
      flush = 1'b0;
      offer(0, 0, 0, 0, 0);
      step();
      chk("flush_nothing", out_valid, 0);

      // Asynchronous reset while full
      offer(1, 32'h00500093, 0, 11, 0);
      step();
      step();
      #2 rst_n = 1'b0;
      #1 chk_reset("arst");
      offer(0, 0, 0, 0, 0);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      offer(1, 32'h00700093, 0, 13, 0);
      step();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_op1", op1, 13);

      // Randomized traffic, checked by the per-cycle compare process
      for (int n = 0; n < 1500; n++) begin
         offer(($urandom_range(0, 9) < 7), rand_inst(), $urandom, $urandom, $urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         flush = ($urandom_range(0, 39) == 0);
         step();
      end
      flush = 1'b0;
      offer(0, 0, 0, 0, 0);
      out_ready = 1'b1;
      step();
      step();

      // XLEN=64 immediates and shamt
      v_in_valid = 1'b1; v_inst = 32'hFFF10093; v_rs1 = 64'h1234;
      step();
      chk("x64_addi_op2", v_op2, 64'hFFFFFFFFFFFFFFFF);
      chk("x64_addi_op1", v_op1, 64'h1234);
      v_inst = 32'h02811093;
      step();
      chk("x64_slli_op2", v_op2, 40);
      chk("x64_slli_sel", v_sel, 2);
      v_in_valid = 1'b0;
      step();
      chk("x64_drained", v_out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
